// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard-controller signal bundle between the pipeline and the stall/flush controller
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        lu_active;
    logic [15:0] stall_cnt;

    // Pipeline side: supplies the hazard-detection inputs, consumes enables/flushes.
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_memread, ex_rd,
               branch_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               lu_active, stall_cnt
    );

    // Controller side.
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_memread, ex_rd,
               branch_taken, mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               lu_active, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for load-use, taken-branch and data-memory wait hazards
module pipeline_hazard_ctrl #(
    parameter int LOAD_USE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic {RUN, LU_STALL} state_t;

    localparam logic [2:0] BC_INIT = 3'(LOAD_USE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  bc_q, bc_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        lu_active_q, lu_active_d;

    logic hazard;
    logic mem_wait;

    always_comb begin
        hazard = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                 ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                  (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
        mem_wait = bus.mem_req && !bus.mem_ready;
    end

    always_comb begin
        state_d        = state_q;
        bc_d           = bc_q;
        bus.pc_en      = 1'b1;
        bus.ifid_en    = 1'b1;
        bus.idex_en    = 1'b1;
        bus.exmem_en   = 1'b1;
        bus.memwb_en   = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;

        if (reset || mem_wait) begin
            // Freeze the whole pipeline; FSM and bubble count hold.
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_en  = 1'b0;
            bus.exmem_en = 1'b0;
            bus.memwb_en = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.branch_taken) begin
                        bus.ifid_flush = 1'b1;
                        bus.idex_flush = 1'b1;
                    end else if (hazard) begin
                        bus.pc_en      = 1'b0;
                        bus.ifid_en    = 1'b0;
                        bus.idex_flush = 1'b1;
                        if (LOAD_USE_CYCLES > 1) begin
                            state_d = LU_STALL;
                            bc_d    = BC_INIT;
                        end
                    end
                end
                LU_STALL: begin
                    // EX holds a bubble here, so branch/hazard inputs are meaningless.
                    bus.pc_en      = 1'b0;
                    bus.ifid_en    = 1'b0;
                    bus.idex_flush = 1'b1;
                    bc_d           = bc_q - 3'd1;
                    if (bc_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        lu_active_d = (state_d == LU_STALL);
        stall_cnt_d = stall_cnt_q;
        if (!bus.pc_en && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            bc_q        <= 3'd0;
            stall_cnt_q <= 16'd0;
            lu_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bc_q        <= bc_d;
            stall_cnt_q <= stall_cnt_d;
            lu_active_q <= lu_active_d;
        end
    end

    assign bus.lu_active = lu_active_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if b1 ();
    pipeline_hazard_ctrl_if b3 ();

    pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
    pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(3)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       mq;
        logic       my;
    } in_t;

    typedef struct {
        string      nm;
        in_t        i;
        logic [6:0] o;   // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    } vec_t;

    localparam logic [6:0] O_RUN   = 7'b1111100;
    localparam logic [6:0] O_STALL = 7'b0011101;
    localparam logic [6:0] O_BR    = 7'b1111111;
    localparam logic [6:0] O_FRZ   = 7'b0000000;

    int n_cmp = 0;
    int n_fail = 0;
    int exp1 = 0;
    int exp3 = 0;

    logic [6:0] o1, o3;
    assign o1 = {b1.pc_en, b1.ifid_en, b1.idex_en, b1.exmem_en, b1.memwb_en, b1.ifid_flush, b1.idex_flush};
    assign o3 = {b3.pc_en, b3.ifid_en, b3.idex_en, b3.exmem_en, b3.memwb_en, b3.ifid_flush, b3.idex_flush};

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic mr, input logic [4:0] rd,
                               input logic br, input logic mq, input logic my);
        in_t r;
        r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.mr = mr;
        r.rd = rd; r.br = br; r.mq = mq; r.my = my;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv1(input in_t v);
        b1.id_rs1 = v.rs1; b1.id_rs2 = v.rs2; b1.id_uses_rs1 = v.u1; b1.id_uses_rs2 = v.u2;
        b1.ex_memread = v.mr; b1.ex_rd = v.rd; b1.branch_taken = v.br;
        b1.mem_req = v.mq; b1.mem_ready = v.my;
    endtask

    task automatic drv3(input in_t v);
        b3.id_rs1 = v.rs1; b3.id_rs2 = v.rs2; b3.id_uses_rs1 = v.u1; b3.id_uses_rs2 = v.u2;
        b3.ex_memread = v.mr; b3.ex_rd = v.rd; b3.branch_taken = v.br;
        b3.mem_req = v.mq; b3.mem_ready = v.my;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    in_t  idle, hz, hzbr, mwait;
    vec_t vt[12];

    initial begin
        idle  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        hz    = mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        hzbr  = mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        mwait = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);

        vt[0]  = '{"no_hazard",      mk(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0), O_RUN};
        vt[1]  = '{"lu_rs1",         hz, O_STALL};
        vt[2]  = '{"lu_rs2",         mk(5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0), O_STALL};
        vt[3]  = '{"rd_zero",        mk(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), O_RUN};
        vt[4]  = '{"not_load",       mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0), O_RUN};
        vt[5]  = '{"rs_unused",      mk(5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0), O_RUN};
        vt[6]  = '{"branch_hazard",  hzbr, O_BR};
        vt[7]  = '{"branch_only",    mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), O_BR};
        vt[8]  = '{"mem_wait",       mwait, O_FRZ};
        vt[9]  = '{"mem_wait_br",    mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0), O_FRZ};
        vt[10] = '{"ready_no_req",   mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1), O_RUN};
        vt[11] = '{"req_ready_lu",   mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1), O_STALL};

        reset = 1'b1;
        drv1(idle);
        drv3(idle);
        step(); step();
        #3;
        chk("reset_out1", {25'd0, o1}, {25'd0, O_FRZ});
        chk("reset_out3", {25'd0, o3}, {25'd0, O_FRZ});
        chk("reset_cnt1", {16'd0, b1.stall_cnt}, 32'd0);
        chk("reset_lu3", {31'd0, b3.lu_active}, 32'd0);

        step();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            drv1(vt[k].i);
            #3;
            chk({"vec_", vt[k].nm}, {25'd0, o1}, {25'd0, vt[k].o});
            chk({"cnt_", vt[k].nm}, {16'd0, b1.stall_cnt}, exp1);
            if (!vt[k].o[6]) exp1++;
            step();
        end
        drv1(idle);
        #3;
        chk("cnt_after_table", {16'd0, b1.stall_cnt}, exp1);
        chk("lu_active_luc1", {31'd0, b1.lu_active}, 32'd0);
        step();

        // LOAD_USE_CYCLES=3: three stall cycles, branch/hazard ignored inside LU_STALL.
        drv3(hz);
        #3;
        chk("lu3_c1_out", {25'd0, o3}, {25'd0, O_STALL});
        chk("lu3_c1_lu", {31'd0, b3.lu_active}, 32'd0);
        exp3++;
        step();
        drv3(hzbr);
        for (int c = 2; c <= 3; c++) begin
            #3;
            chk($sformatf("lu3_c%0d_out", c), {25'd0, o3}, {25'd0, O_STALL});
            chk($sformatf("lu3_c%0d_lu", c), {31'd0, b3.lu_active}, 32'd1);
            exp3++;
            step();
        end
        drv3(idle);
        #3;
        chk("lu3_done_out", {25'd0, o3}, {25'd0, O_RUN});
        chk("lu3_done_lu", {31'd0, b3.lu_active}, 32'd0);
        chk("lu3_done_cnt", {16'd0, b3.stall_cnt}, exp3);
        step();

        // Memory wait inside LU_STALL with two bubbles left.
        drv3(hz);
        exp3++;
        step();
        drv3(mwait);
        for (int c = 0; c < 4; c++) begin
            #3;
            chk($sformatf("lu_mw%0d_out", c), {25'd0, o3}, {25'd0, O_FRZ});
            chk($sformatf("lu_mw%0d_lu", c), {31'd0, b3.lu_active}, 32'd1);
            exp3++;
            step();
        end
        drv3(idle);
        for (int c = 0; c < 2; c++) begin
            #3;
            chk($sformatf("lu_mw_resume%0d", c), {25'd0, o3}, {25'd0, O_STALL});
            exp3++;
            step();
        end
        #3;
        chk("lu_mw_done_out", {25'd0, o3}, {25'd0, O_RUN});
        chk("lu_mw_done_cnt", {16'd0, b3.stall_cnt}, exp3);
        step();

        // Back-to-back: a hazard right after the stall starts a new one.
        drv3(hz);
        step(); step();
        #3;
        chk("b2b_lu_end", {31'd0, b3.lu_active}, 32'd1);
        step();
        #3;
        chk("b2b_new_hazard", {25'd0, o3}, {25'd0, O_STALL});
        chk("b2b_new_lu", {31'd0, b3.lu_active}, 32'd0);
        step();

        // Asynchronous reset in the middle of LU_STALL.
        #3;
        chk("pre_reset_lu", {31'd0, b3.lu_active}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_reset_out", {25'd0, o3}, {25'd0, O_FRZ});
        chk("mid_reset_lu", {31'd0, b3.lu_active}, 32'd0);
        chk("mid_reset_cnt", {16'd0, b3.stall_cnt}, 32'd0);
        drv3(idle);
        step();
        reset = 1'b0;
        #3;
        chk("post_reset_out", {25'd0, o3}, {25'd0, O_RUN});
        step();
        #3;
        chk("post_reset_lu", {31'd0, b3.lu_active}, 32'd0);
        chk("post_reset_cnt", {16'd0, b3.stall_cnt}, 32'd0);

        // Saturation: long memory wait on the LOAD_USE_CYCLES=1 instance.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        drv1(mwait);
        for (int c = 0; c < 65534; c++) @(posedge clk);
        #1;
        chk("sat_fffe", {16'd0, b1.stall_cnt}, 32'h0000FFFE);
        for (int c = 0; c < 3; c++) @(posedge clk);
        #1;
        chk("sat_ffff", {16'd0, b1.stall_cnt}, 32'h0000FFFF);
        chk("sat_pc_en", {31'd0, b1.pc_en}, 32'd0);
        drv1(idle);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It drives the `enable` inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the flush (bubble-insert) controls of IF/ID and ID/EX. It resolves three conditions: load-use hazards with a configurable multi-cycle stall, taken branches resolved in EX, and data-memory wait states. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..7.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- id_rs1  input  5  source register 1 of the instruction in ID
- id_rs2  input  5  source register 2 of the instruction in ID
- id_uses_rs1  input  1  ID instruction reads rs1
- id_uses_rs2  input  1  ID instruction reads rs2
- ex_memread  input  1  instruction in EX is a load
- ex_rd  input  5  destination register of the instruction in EX
- branch_taken  input  1  EX resolved a taken branch/jump this cycle
- mem_req  input  1  MEM stage has an active data-memory access
- mem_ready  input  1  data memory completes the access this cycle
- pc_en  output  1  PC enable
- ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline-register enables
- ifid_flush  output  1  IF/ID loads all-zero (NOP) on this edge
- idex_flush  output  1  ID/EX loads all-zero (bubble) on this edge
- lu_active  output  1  FSM is in LU_STALL
- stall_cnt  output  16  count of cycles with pc_en==0

## Operation
- hazard = ex_memread & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- mem_wait = mem_req & ~mem_ready. This has top priority in every state:
  - all five enables = 0, both flushes = 0;
  - FSM state and bubble counter hold.
- FSM states are RUN and LU_STALL. A 3-bit bubble counter `bc` is internal.
- RUN, no mem_wait, priority order:
  - branch_taken: all enables 1, ifid_flush=1, idex_flush=1; stay RUN. The branch takes priority over a simultaneous hazard.
  - hazard: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1.
    - If LOAD_USE_CYCLES==1: stay RUN.
    - Otherwise: go to LU_STALL with bc=LOAD_USE_CYCLES-1.
  - otherwise: all enables 1, flushes 0.
- LU_STALL, no mem_wait:
  - outputs are the same as the RUN hazard case;
  - bc decrements; when bc==1 on this cycle, next state is RUN.
  - branch_taken and hazard are ignored, because EX holds a bubble.
- Flush has priority over enable inside the pipeline register: a register with flush=1 and en=1 loads zero.
- stall_cnt increments by 1 every cycle in which pc_en==0 and reset is low. It saturates at 16'hFFFF.

## Timing
- All enable/flush outputs are combinational from state and inputs, valid in the same cycle. There are no registered outputs except lu_active and stall_cnt.
- While reset is high:
  - state=RUN, bc=0, stall_cnt=0, lu_active=0;
  - all enables 0, flushes 0.
- Reset asserted mid-stall: the FSM returns to RUN immediately (asynchronously). The stall is not resumed after reset.
- Load-use penalty = LOAD_USE_CYCLES cycles. Taken-branch penalty = 2 cycles (two flushed slots).
- Back-to-back hazards: a new hazard is evaluated on the first RUN cycle after a stall.
- mem_ready arriving while mem_req=0 is ignored.
- mem_wait during LU_STALL extends the stall by the number of wait cycles. The bubble count is unchanged.

## Test plan
- Load-use, LOAD_USE_CYCLES=1: ex_memread=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> that cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1; stall_cnt=1.
- ex_rd=0 with a matching rs1 and ex_memread=1 -> no stall; all enables 1.
- LOAD_USE_CYCLES=3 hazard -> pc_en=0 for exactly 3 cycles, lu_active=1 for cycles 2-3, then RUN; stall_cnt=3.
- branch_taken=1 together with a hazard -> ifid_flush=1, idex_flush=1, pc_en=1, stall_cnt unchanged.
- mem_req=1, mem_ready=0 for 4 cycles during LU_STALL with bc=2 -> all enables 0 for 4 cycles; the stall then resumes with 2 remaining bubbles; stall_cnt += 4 plus the remaining bubbles.
- Reset pulse mid-LU_STALL -> outputs immediately all 0; after release state=RUN, stall_cnt=0. Also preload to 16'hFFFE, stall 3 cycles -> stall_cnt holds 16'hFFFF.
